macci_multi: RTL and testbench
==============================

# macci_multi

Parametrised multi-accumulator multiply-accumulate unit for the Nios II multi-cycle custom-instruction slot. It is the successor to the single-accumulator MAC and adds selectable accumulator banks, a wide accumulator, a pipelined multiplier, subtract, non-destructive read, arithmetic read-out shift and optional saturation. It sits on the custom-instruction port of the CPU; `n` carries opcode and accumulator index.

## Interface
- `ACC_W`, 48: accumulator width in bits. Legal range 32..64.
- `NUM_ACC`, 4: number of accumulators. Legal range 1..32.
- `MUL_LAT`, 2: multiplier pipeline stages. Legal range 1..4.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `clk_en` in 1: CPU clock enable. Low freezes every register, including `done`.
- `n` in 8: `n[2:0]` is the opcode and `n[7:3]` the accumulator index.
- `start` in 1: one-cycle instruction strobe, qualified by `clk_en`.
- `dataa` in 32: signed operand A.
- `datab` in 32: signed operand B. It is the read-out shift amount for read ops.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: read-out value, held until the next read op.

## Operation
- **FSM states:** IDLE, MUL (multiplier pipeline in flight), FIN (done cycle). IDLE→MUL on an accepted multiply op; MUL→FIN after `MUL_LAT` enabled cycles; FIN→IDLE. Non-multiply ops go IDLE→FIN directly.
- **Acceptance:** `start & clk_en` is accepted only in IDLE. `start` in any other state is ignored and never queued.
- **Product:** full signed 32×32 = 64-bit product, then sign-truncated to `ACC_W`.
- **Opcodes** (i = `n[7:3]`):
  - 0 NOP.
  - 1 MAC: acc[i] += p.
  - 2 READ_CLR: result = f(acc[i]), then acc[i] = 0.
  - 3 LOAD: acc[i] = p.
  - 4 MSU: acc[i] -= p.
  - 5 READ: result = f(acc[i]); acc unchanged.
  - 6 CLR_ALL: every acc = 0.
  - 7: treated as NOP.
- **Bad index:** if i ≥ `NUM_ACC`, no accumulator changes, read ops set result = 0, and `done` still pulses with normal latency.
- **Read-out f(x):** x arithmetically shifted right by `datab[5:0]`, then the low 32 bits are taken. A shift ≥ `ACC_W` yields all sign bits.
- **Arithmetic without saturation:** wraps modulo 2^`ACC_W`.
- **Reset:** clears all accumulators, FSM → IDLE, `done` = 0, `result` = 0. Any in-flight op is discarded and never produces `done`.
- **`result`** changes only on read ops (2, 5) and on reset.

## Timing
- Counts below are enabled cycles after the accepting edge.
- **Multiply ops (1, 3, 4):** `done` high in cycle `MUL_LAT`+1; acc[i] is updated at the same edge that raises `done`.
- **Ops 0, 2, 5, 6, 7:** `done` high in cycle 1; `result` and accumulators are valid at the same edge.
- `done` is high for exactly one enabled cycle. The next `start` may be accepted in the cycle `done` is high, because FIN accepts like IDLE. Back-to-back throughput is therefore `MUL_LAT`+1 cycles per multiply op.
- `clk_en` low mid-operation stretches latency by the number of disabled cycles. A `done` pending when `clk_en` drops stays high until `clk_en` returns.
- Reset takes priority over `clk_en`.

## Configuration
- **`MACCI_SAT_EN` defined:**
  - MAC, MSU and LOAD results clamp to the signed `ACC_W` limits instead of wrapping.
  - Read-out clamps the shifted value to [0x8000_0000, 0x7FFF_FFFF] before truncation.
  - A sticky `sat` flag is set by any clamp and is returned in `result` by opcode 7, as `{31'b0, sat}`.
  - `sat` is cleared by reset or CLR_ALL.
- **Undefined:** wrap-around arithmetic, plain truncation, and opcode 7 is a NOP.

## Test plan
- **Reset then basic MAC:** reset, then MAC acc0 with 3×4 and MAC acc0 with −2×5. READ_CLR acc0 with shift 0 gives `result` = 2, and a following READ acc0 gives 0.
- **Latency:** with `MUL_LAT`=2, `done` rises exactly 3 cycles after MAC `start` and 1 cycle after READ `start`. A `start` issued while busy produces no extra `done`.
- **Independent channels:** LOAD acc1 = 7×7 and MSU acc3 −= 2×3. READ acc1 gives 49 and READ acc3 gives −6 (0xFFFF_FFFA). Bad index 31 gives `result` = 0 with `done` pulsed.
- **Shift and width:** LOAD 0x4000_0000 × 0x10 (= 2^34), then READ with shift 4 gives 0x4000_0000. Without the macro, READ with shift 0 gives 0.
- **Wrap vs. saturation:** with `ACC_W`=48, MAC 0x7FFF_FFFF² twice. Without the macro the value wraps. With `MACCI_SAT_EN`, the acc holds 0x7FFF_FFFF_FFFF, READ with shift 0 gives 0x7FFF_FFFF, and opcode 7 returns 1.
- **Stall and reset mid-op:** drop `clk_en` for 5 cycles during a MAC; `done` is delayed 5 cycles. Assert `reset` during MUL; `done` never fires and all accumulators read 0.

Source files
------------

// File: rtl/macci_multi.sv
// rtl/macci_multi.sv - multi-accumulator MAC custom instruction with pipelined multiplier
// Optional saturating arithmetic and sticky sat flag (opcode 7) when MACCI_SAT_EN is defined.
module macci_multi #(
    parameter int ACC_W   = 48,
    parameter int NUM_ACC = 4,
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [7:0]  n,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);

`ifdef MACCI_SAT_EN
    localparam int PW = 64;
    localparam int WW = 66;
    localparam logic signed [65:0] ACC_MAX = (66'sd1 <<< (ACC_W - 1)) - 66'sd1;
    localparam logic signed [65:0] ACC_MIN = -(66'sd1 <<< (ACC_W - 1));
    localparam logic signed [ACC_W-1:0] RD_MAX = ACC_W'(64'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] RD_MIN = ACC_W'(-64'sh8000_0000);
`else
    localparam int PW = ACC_W;
    localparam int WW = ACC_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

    state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] result_q, result_d;
    logic signed [PW-1:0]    pipe_q [MUL_LAT];
    logic signed [PW-1:0]    pipe_d [MUL_LAT];
    logic signed [ACC_W-1:0] acc_q [NUM_ACC];
    logic signed [ACC_W-1:0] acc_d [NUM_ACC];
`ifdef MACCI_SAT_EN
    logic sat_q, sat_d;
    logic mul_clamp, rd_clamp;
`endif

    logic        accept, mul_done, rd_hit;
    logic [2:0]  op_in;
    logic [4:0]  idx_in;
    logic signed [PW-1:0]    a_ext, b_ext;
    logic signed [ACC_W-1:0] rd_acc, mul_acc, rd_shift, acc_new;
    logic signed [WW-1:0]    sum;
    logic [31:0] rd_val;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
    endfunction

    assign op_in    = n[2:0];
    assign idx_in   = n[7:3];
    assign accept   = start && clk_en && (state_q != S_MUL);
    assign mul_done = (state_q == S_MUL) && (cnt_q == 3'(MUL_LAT - 1));
    assign result   = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIN accepts a new instruction exactly like IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (accept) begin
                    state_d = is_mul(op_in) ? S_MUL : S_FIN;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) state_d = S_FIN;
                else          cnt_d   = cnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == S_FIN);
    end

    always_comb begin
        rd_acc  = '0;
        rd_hit  = 1'b0;
        mul_acc = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (idx_in == 5'(i)) begin
                rd_acc = acc_q[i];
                rd_hit = 1'b1;
            end
            if (idx_q == 5'(i)) mul_acc = acc_q[i];
        end
    end

    always_comb begin
        a_ext     = PW'($signed(dataa));
        b_ext     = PW'($signed(datab));
        pipe_d[0] = a_ext * b_ext;
        for (int k = 1; k < MUL_LAT; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_comb begin
        case (op_q)
            3'd1:    sum = WW'(mul_acc) + WW'(pipe_q[MUL_LAT-1]);
            3'd4:    sum = WW'(mul_acc) - WW'(pipe_q[MUL_LAT-1]);
            default: sum = WW'(pipe_q[MUL_LAT-1]);
        endcase
        rd_shift = rd_acc >>> datab[5:0];
`ifdef MACCI_SAT_EN
        mul_clamp = 1'b1;
        rd_clamp  = 1'b1;
        if (sum > ACC_MAX)      acc_new = ACC_W'(ACC_MAX);
        else if (sum < ACC_MIN) acc_new = ACC_W'(ACC_MIN);
        else begin
            acc_new   = ACC_W'(sum);
            mul_clamp = 1'b0;
        end
        if (rd_shift > RD_MAX)      rd_val = 32'h7FFF_FFFF;
        else if (rd_shift < RD_MIN) rd_val = 32'h8000_0000;
        else begin
            rd_val   = 32'(rd_shift);
            rd_clamp = 1'b0;
        end
`else
        acc_new = sum;
        rd_val  = 32'(rd_shift);
`endif
    end

    always_comb begin
        op_d     = op_q;
        idx_d    = idx_q;
        result_d = result_q;
        for (int i = 0; i < NUM_ACC; i++) acc_d[i] = acc_q[i];
`ifdef MACCI_SAT_EN
        sat_d = sat_q;
`endif
        // Out-of-range indices match no accumulator, so writes simply drop
        if (mul_done) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (idx_q == 5'(i)) begin
                    acc_d[i] = acc_new;
`ifdef MACCI_SAT_EN
                    if (mul_clamp) sat_d = 1'b1;
`endif
                end
            end
        end
        if (accept) begin
            op_d  = op_in;
            idx_d = idx_in;
            case (op_in)
                3'd2, 3'd5: begin
                    result_d = rd_hit ? rd_val : 32'd0;
`ifdef MACCI_SAT_EN
                    if (rd_hit && rd_clamp) sat_d = 1'b1;
`endif
                    if (op_in == 3'd2) begin
                        for (int i = 0; i < NUM_ACC; i++)
                            if (idx_in == 5'(i)) acc_d[i] = '0;
                    end
                end
                3'd6: begin
                    for (int i = 0; i < NUM_ACC; i++) acc_d[i] = '0;
`ifdef MACCI_SAT_EN
                    sat_d = 1'b0;
`endif
                end
`ifdef MACCI_SAT_EN
                3'd7: result_d = {31'b0, sat_q};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            idx_q    <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= '0;
`ifdef MACCI_SAT_EN
            sat_q <= 1'b0;
`endif
        end else if (clk_en) begin
            op_q     <= op_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_d[i];
            for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= pipe_d[k];
`ifdef MACCI_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_macci_multi.sv
// tb/tb_macci_multi.sv - self-checking bench for macci_multi against a transaction-level model
module tb_macci_multi;
    localparam int ACC_W   = 48;
    localparam int NUM_ACC = 4;
    localparam int MUL_LAT = 2;

    typedef logic signed [127:0] big_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n = '0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_on = 0;

    big_t        m_acc [NUM_ACC];
    logic [31:0] m_res;
    bit          m_sat;
    longint      en_cnt;
    longint      done_at;

    macci_multi #(.ACC_W(ACC_W), .NUM_ACC(NUM_ACC), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .n(n), .start(start),
        .dataa(dataa), .datab(datab), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic big_t fit(input big_t x, output bit clamped);
        big_t lim;
        lim = big_t'(1) <<< (ACC_W - 1);
        clamped = 0;
`ifdef MACCI_SAT_EN
        if (x >= lim) begin clamped = 1; return lim - 1; end
        if (x < -lim) begin clamped = 1; return -lim; end
        return x;
`else
        return (x <<< (128 - ACC_W)) >>> (128 - ACC_W);
`endif
    endfunction

    function automatic logic [31:0] readout(input big_t x, input int sh, output bit clamped);
        big_t y;
        big_t hi;
        big_t lo;
        y  = x >>> sh;
        hi = (big_t'(1) <<< 31) - 1;
        lo = -(big_t'(1) <<< 31);
        clamped = 0;
`ifdef MACCI_SAT_EN
        if (y > hi) begin clamped = 1; return 32'h7FFF_FFFF; end
        if (y < lo) begin clamped = 1; return 32'h8000_0000; end
`endif
        return y[31:0];
    endfunction

    // Transaction model: effects applied at the accepting edge, done scheduled in enabled cycles
    always @(posedge clk) begin : model
        int   op;
        int   idx;
        int   lat;
        big_t p;
        bit   c;
        if (reset) begin
            foreach (m_acc[i]) m_acc[i] = 0;
            m_res   = 0;
            m_sat   = 0;
            en_cnt  = 0;
            done_at = -1;
        end else if (clk_en) begin
            if (start && en_cnt >= done_at) begin
                op  = int'(n[2:0]);
                idx = int'(n[7:3]);
                p   = big_t'($signed(dataa)) * big_t'($signed(datab));
                lat = 1;
                case (op)
                    1, 3, 4: begin
                        lat = MUL_LAT + 1;
                        if (idx < NUM_ACC) begin
                            m_acc[idx] = fit(op == 3 ? p : (op == 1 ? m_acc[idx] + p : m_acc[idx] - p), c);
                            if (c) m_sat = 1;
                        end
                    end
                    2, 5: begin
                        if (idx < NUM_ACC) begin
                            m_res = readout(m_acc[idx], int'(datab[5:0]), c);
                            if (c) m_sat = 1;
                            if (op == 2) m_acc[idx] = 0;
                        end else begin
                            m_res = 0;
                        end
                    end
                    6: begin
                        foreach (m_acc[i]) m_acc[i] = 0;
                        m_sat = 0;
                    end
                    7: begin
`ifdef MACCI_SAT_EN
                        m_res = {31'b0, m_sat};
`endif
                    end
                    default: ;
                endcase
                done_at = en_cnt + lat;
            end
            en_cnt++;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("done", done, (en_cnt == done_at));
            check("result", result, m_res);
        end
    end

    // mode: 0 plain, 1 start poked while busy, 2 clk_en low 5 cycles mid-op, 3 clk_en low 3 cycles on done
    task automatic do_op(input int op, input int idx, input logic [31:0] a, input logic [31:0] b,
                         input bit now, input int mode, input string name, output int lat);
        int exp_lat;
        if (!now) @(negedge clk);
        n     = {idx[4:0], op[2:0]};
        dataa = a;
        datab = b;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                if (mode == 1) begin start = 1'b1; n = 8'h05; end
                if (mode == 2) clk_en = 1'b0;
            end
            if (k == 2 && mode == 1) start = 1'b0;
            if (k == 6 && mode == 2) clk_en = 1'b1;
            if (done) begin lat = k; break; end
        end
        if (mode == 3 && lat > 0) begin
            clk_en = 1'b0;
            repeat (3) @(negedge clk);
            clk_en = 1'b1;
        end
        exp_lat = (op == 1 || op == 3 || op == 4) ? MUL_LAT + 1 + (mode == 2 ? 5 : 0) : 1;
        check({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int op;
        int idx;
        int mode;
        bit now;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1;
        @(posedge clk);
        cmp_on = 1;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;

        do_op(1, 0, 3, 4, 0, 0, "mac_a", lat);
        check("lat_mac_literal", lat, 3);
        do_op(1, 0, -2, 5, 0, 0, "mac_b", lat);
        do_op(2, 0, 0, 0, 0, 0, "rdclr0", lat);
        check("lat_read_literal", lat, 1);
        check("rdclr_acc0", result, 2);
        do_op(5, 0, 0, 0, 0, 0, "rd0", lat);
        check("read_acc0_cleared", result, 0);
        do_op(1, 2, 1, 1, 0, 1, "mac_busy", lat);
        check("lat_busy_literal", lat, 3);

        do_op(3, 1, 7, 7, 0, 0, "load1", lat);
        do_op(4, 3, 2, 3, 0, 0, "msu3", lat);
        do_op(5, 1, 0, 0, 0, 0, "rd1", lat);
        check("read_acc1", result, 49);
        do_op(5, 3, 0, 0, 0, 0, "rd3", lat);
        check("read_acc3", result, 32'hFFFF_FFFA);
        do_op(5, 31, 0, 0, 0, 0, "rd_bad", lat);
        check("read_bad_idx", result, 0);
        do_op(5, 3, 0, 50, 0, 0, "rd3_sh50", lat);
        check("read_acc3_bigshift", result, 32'hFFFF_FFFF);
        do_op(2, 31, 0, 0, 0, 0, "rdclr_bad", lat);
        check("rdclr_bad_idx", result, 0);

        do_op(3, 2, 32'h4000_0000, 32'h10, 0, 0, "load_wide", lat);
        do_op(5, 2, 0, 4, 0, 0, "rd_sh4", lat);
        check("read_wide_sh4", result, 32'h4000_0000);
        do_op(5, 2, 0, 0, 0, 0, "rd_sh0", lat);
`ifdef MACCI_SAT_EN
        check("read_wide_sh0", result, 32'h7FFF_FFFF);
`else
        check("read_wide_sh0", result, 0);
`endif

        do_op(6, 0, 0, 0, 0, 0, "clr_all", lat);
        do_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, "mac_big1", lat);
        do_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, "mac_big2", lat);
        do_op(5, 0, 0, 0, 0, 0, "rd_big", lat);
`ifdef MACCI_SAT_EN
        check("read_big_sh0", result, 32'h7FFF_FFFF);
`else
        check("read_big_sh0", result, 2);
`endif
        do_op(5, 0, 0, 16, 0, 0, "rd_big16", lat);
`ifdef MACCI_SAT_EN
        check("read_big_sh16", result, 32'h7FFF_FFFF);
        do_op(7, 0, 0, 0, 0, 0, "op7", lat);
        check("op7_sat", result, 1);
`else
        check("read_big_sh16", result, 32'hFFFE_0000);
        do_op(7, 0, 0, 0, 0, 0, "op7", lat);
        check("op7_nop", result, 32'hFFFE_0000);
`endif

        do_op(1, 1, 1, 1, 0, 0, "b2b_mac", lat);
        do_op(5, 1, 0, 0, 1, 0, "b2b_rd", lat);
        check("b2b_read_acc1", result, 1);
        do_op(1, 1, 2, 3, 0, 2, "stall_mac", lat);
        check("lat_stall_literal", lat, 8);
        do_op(5, 1, 0, 0, 0, 3, "hold_rd", lat);
        check("hold_read_acc1", result, 7);

        @(negedge clk);
        n     = {5'd1, 3'd1};
        dataa = 5;
        datab = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_mid_no_done", done, 0);
        for (int i = 0; i < NUM_ACC; i++) begin
            do_op(5, i, 0, 0, 0, 0, "rd_after_reset", lat);
            check("acc_after_reset", result, 0);
        end

        for (int t = 0; t < 300; t++) begin
            op  = int'($urandom_range(0, 7));
            idx = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, NUM_ACC + 1));
            a   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40) - 20;
            b   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40) - 20;
            if (op == 2 || op == 5)
                b[5:0] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 40));
            if (op == 1 || op == 3 || op == 4) mode = int'($urandom_range(0, 3));
            else mode = $urandom_range(0, 1) ? 3 : 0;
            now = 1'($urandom_range(0, 1));
            do_op(op, idx, a, b, now, mode, "rnd", lat);
        end

        for (int i = 0; i < NUM_ACC; i++) begin
            do_op(5, i, 0, $urandom_range(0, 20), 0, 0, "final_rd", lat);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
